// File: rtl/disp_scan_decoder.sv
// Rebuilds the four hex digits and decimal points from a scanned anode/segment bus.
// Each scan slot must hold steady before it is accepted; illegal slots raise one-cycle pulses.
module disp_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic       code_err,
  output logic       an_err,
  output logic       stale
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

  logic [11:0]             smp_s1;
  logic [11:0]             smp_s2;
  logic [CNT_W-1:0]        stab_cnt;
  logic                    same;
  logic                    accept;
  logic                    dec_ok;
  logic [3:0]              dec_val;
  logic                    an_hot;
  logic                    an_blank;
  logic [1:0]              an_pos;
  logic [3:0]              seen;
  logic [3:0]              seen_next;
  logic [3:0]              hex_r [4];
  logic [3:0]              dp_r;
  logic [TIMEOUT_BITS-1:0] tmo_cnt;

  assign same   = (smp_s1 == smp_s2);
  // Fires only on the transition into the saturated count, so one accept per stable run.
  assign accept = same && (stab_cnt == CNT_PRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_s1   <= '0;
      smp_s2   <= '0;
      stab_cnt <= '0;
    end else begin
      smp_s1 <= {an, sseg};
      smp_s2 <= smp_s1;
      if (!same) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (smp_s2[6:0])
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'ha;
      7'b1100000: dec_val = 4'hb;
      7'b0110001: dec_val = 4'hc;
      7'b1000010: dec_val = 4'hd;
      7'b0110000: dec_val = 4'he;
      7'b0111000: dec_val = 4'hf;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    an_hot = 1'b0;
    an_pos = 2'd0;
    case (smp_s2[11:8])
      4'b1110: begin an_hot = 1'b1; an_pos = 2'd0; end
      4'b1101: begin an_hot = 1'b1; an_pos = 2'd1; end
      4'b1011: begin an_hot = 1'b1; an_pos = 2'd2; end
      4'b0111: begin an_hot = 1'b1; an_pos = 2'd3; end
      default: begin an_hot = 1'b0; an_pos = 2'd0; end
    endcase
  end

  assign an_blank  = (smp_s2[11:8] == 4'b1111);
  assign seen_next = seen | (4'b0001 << an_pos);

  // Accepts are at least two edges apart, so the post-frame clear never collides with one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) hex_r[i] <= 4'h0;
      dp_r        <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      an_err      <= 1'b0;
      if (frame_valid) begin
        seen <= '0;
      end
      if (accept) begin
        if (an_hot) begin
          if (dec_ok) begin
            hex_r[an_pos] <= dec_val;
            dp_r[an_pos]  <= smp_s2[7];
            seen          <= seen_next;
            frame_valid   <= (seen_next == 4'b1111);
          end else begin
            code_err <= 1'b1;
          end
        end else if (!an_blank) begin
          an_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (frame_valid) begin
      tmo_cnt <= '0;
    end else if (!(&tmo_cnt)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign stale       = &tmo_cnt;
  assign hex0        = hex_r[0];
  assign hex1        = hex_r[1];
  assign hex2        = hex_r[2];
  assign hex3        = hex_r[3];
  assign dp_out      = dp_r;
  assign digit_valid = seen;

endmodule

// File: doc/disp_scan_decoder.md
Name: disp_scan_decoder

Overview:
- Receive-side counterpart of the team's multiplexed seven-segment driver. Watches the scanned anode/segment bus (an, sseg) and rebuilds the four hex digits and four decimal-point bits.
- Applies a stability filter to each scan slot, flags illegal patterns and reports frame completion.
- Used for on-chip loopback self-test and bench checking of display paths. Inputs are in the same clk domain as the driver.

Parameters:
STABLE_CYCLES, 4, consecutive sampled cycles a pattern must hold before it is accepted (>=2)
TIMEOUT_BITS, 20, width of frame-timeout counter; stale asserts after 2^TIMEOUT_BITS-1 cycles without a frame

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
an  input  4  digit enables, active-low, one-hot-low when driving a digit
sseg  input  8  sseg[6:0]={a,b,c,d,e,f,g} active-low segments; sseg[7]=dp, raw driver polarity
hex3, hex2, hex1, hex0  output  4 each  last accepted digit value per position
dp_out  output  4  last accepted sseg[7] per position, bit i = digit i
digit_valid  output  4  bit i set once digit i has been accepted in the current frame
frame_valid  output  1  one-cycle pulse when all four digits have been accepted
code_err  output  1  one-cycle pulse: accepted segment pattern not in decode table
an_err  output  1  one-cycle pulse: accepted an is neither one-hot-low nor 4'b1111
stale  output  1  level: no frame_valid within the timeout window

Behaviour:
- Reset (reset=0, async): all outputs 0, input sample registers 0, stability counter 0, seen mask 0, timeout counter 0. It takes effect immediately, including mid-frame; partial frame content is discarded.
- Stage 1 registers {an, sseg} every clk. Stage 2 compares the stage-1 value with its previous value:
  - Changed: stability counter := 0.
  - Unchanged: counter increments, saturating at STABLE_CYCLES-1.
  - Accept event fires on the single cycle the counter transitions to STABLE_CYCLES-1, so there is one accept per stable interval.
- Latency: the pattern is present at the inputs before edge 1. On edge STABLE_CYCLES+1, the outputs update and pulses assert.
- On accept, decode sseg[6:0] with the table below, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, a=0001000, b=1100000, c=0110001, d=1000010, e=0110000, f=0111000
- Accept action by an value:
  - an one-hot-low at position i, legal code: hex_i := decoded value; dp_out[i] := sseg[7]; seen[i] := 1.
  - an one-hot-low at position i, illegal code: code_err pulse; hex_i, dp_out[i] and seen unchanged.
  - an=4'b1111 (blank): ignored, no error.
  - Any other an: an_err pulse; nothing else changes.
- Same digit accepted twice in a frame: newest value overwrites, no error.
- Frame completion:
  - When an accept makes seen=4'b1111, frame_valid pulses for that cycle, with the hex/dp updates visible on the same cycle.
  - seen clears to 0000 on the following edge.
  - digit_valid = seen.
- Timeout counter: increments every clk, saturating at all-ones, and clears on frame_valid. stale = (counter == all-ones), asserted while saturated. A frame_valid deasserts stale on the next edge.
- Pulses are registered and last exactly one cycle. code_err and an_err cannot coincide with each other; either may coincide with stale.

Test Plan:
- an=1110, sseg=8'b0_0000001 held 10 cycles from reset → hex0=0, dp_out[0]=0, digit_valid=0001 after edge 5; no pulses.
- Frame: 8 cycles each of 1110/'9'(dp=1), 1101/'a'(dp=0), 1011/'b'(dp=1), 0111/'f'(dp=0) → single frame_valid pulse on the 'f' accept; {hex3..hex0}=f,b,a,9; dp_out=0101; digit_valid then 0000.
- Glitch: 1101/'3' held 3 cycles between stable 1110/'1' slots → hex1 unchanged, no digit_valid[1], no pulse; held 4 cycles → hex1=3.
- Errors: 1110 with 7'b1111110 held 8 cycles → exactly one code_err, hex0 unchanged. an=1100 held 8 cycles → exactly one an_err. an=1111 held 8 cycles → no pulse.
- Stale: TIMEOUT_BITS=4, no frame for 15 cycles → stale=1; complete a frame → stale=0 the edge after frame_valid.
- Reset mid-frame: accept digits 0 and 1, pull reset low for 1 cycle → all outputs 0 immediately. Then supply digits 2 and 3 → no frame_valid until 0 and 1 are re-accepted.
